// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// handshake and holds one instruction for the IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        ins_valid
);

  localparam logic [31:0] STEP = 32'(INSTR_BYTES);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_inflight;
  logic         buf_free;
  logic         grant;

  // Only request when the buffer will be empty by the time the response lands.
  assign buf_free  = !ins_valid || !fetch_stall;
  assign imem_req  = !reset && (state == FETCH) && buf_free;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pc_inflight <= RESET_PC;
      ins_out     <= NOP_INSTR;
      pc_out      <= 32'h0;
      ins_valid   <= 1'b0;
    end else begin
      if (ins_valid && !fetch_stall) begin
        ins_valid <= 1'b0;
        ins_out   <= NOP_INSTR;
        pc_out    <= 32'h0;
      end

      case (state)
        FETCH: if (grant) begin
          pc_inflight <= pc;
          pc          <= pc + STEP;
          state       <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          ins_out   <= imem_rdata;
          pc_out    <= pc_inflight + STEP;
          ins_valid <= 1'b1;
          state     <= FETCH;
        end
        DRAIN: if (imem_rvalid) state <= FETCH;
        default: state <= FETCH;
      endcase

      // Redirect overrides everything above; a granted-but-unreturned
      // request must have its response drained.
      if (redirect) begin
        pc        <= {redirect_pc[31:2], 2'b00};
        ins_valid <= 1'b0;
        ins_out   <= NOP_INSTR;
        pc_out    <= 32'h0;
        case (state)
          FETCH:       state <= grant ? DRAIN : FETCH;
          WAIT, DRAIN: state <= imem_rvalid ? FETCH : DRAIN;
          default:     state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, fetch_stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ins_out, pc_out;
  logic        ins_valid;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .fetch_stall(fetch_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ins_out(ins_out), .pc_out(pc_out), .ins_valid(ins_valid)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  // model: next fetch address, one pending request (maybe killed), one-entry buffer
  logic [31:0] m_pc = RPC, m_paddr = 0, m_bins = 0, m_bpc = 0;
  logic        m_pend = 0, m_kill = 0, m_bv = 0;

  // memory: single outstanding, programmable grant/response delays
  logic        mb_busy = 0;
  logic [31:0] mb_addr = 0;
  int          mb_cnt = 0, mb_reqcnt = 0, g_dly = 0, r_dly = 1;
  logic        rnd_mem = 0;

  logic        s_req, s_valid, s_gnt, s_fired;
  logic [31:0] s_addr, s_pc, s_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic rd,
                      input logic [31:0] rpc, input logic rd_on_req);
    logic exp_req, grant, rv;
    @(negedge clk);
    reset = rst; fetch_stall = stl; redirect = rd; redirect_pc = rpc;
    rv = mb_busy && (mb_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(mb_addr) : $urandom;
    #1;
    s_fired = 1'b0;
    if (rd_on_req && imem_req) begin
      redirect = 1'b1;
      s_fired  = 1'b1;
    end
    grant = imem_req && !mb_busy && (mb_reqcnt >= g_dly);
    imem_gnt = grant;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = ins_valid;
    s_pc = pc_out; s_ins = ins_out; s_gnt = grant;

    exp_req = !rst && !m_pend && (!m_bv || !stl);
    chk("imem_req", s_req, exp_req);
    if (exp_req) chk("imem_addr", s_addr, m_pc);
    chk("ins_valid", s_valid, m_bv);
    chk("ins_out", s_ins, m_bins);
    chk("pc_out", s_pc, m_bpc);

    if (rst) begin
      m_pc = RPC; m_pend = 0; m_kill = 0; m_bv = 0; m_bins = 0; m_bpc = 0;
    end else begin
      if (m_bv && !stl) begin m_bv = 0; m_bins = 0; m_bpc = 0; end
      if (m_pend && rv) begin
        if (!m_kill) begin m_bv = 1; m_bins = imem_rdata; m_bpc = m_paddr + 32'd4; end
        m_pend = 0;
      end
      if (exp_req && grant) begin
        m_pend = 1; m_kill = 0; m_paddr = m_pc; m_pc = m_pc + 32'd4;
      end
      if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_bv = 0; m_bins = 0; m_bpc = 0;
        if (m_pend) m_kill = 1;
      end
    end

    if (rv) mb_busy = 0;
    else if (mb_busy) mb_cnt--;
    if (grant) begin
      mb_busy = 1; mb_addr = imem_addr; mb_cnt = r_dly - 1; mb_reqcnt = 0;
      if (rnd_mem) begin g_dly = $urandom_range(0, 3); r_dly = $urandom_range(1, 3); end
    end else if (imem_req) mb_reqcnt++;
    else mb_reqcnt = 0;
  endtask

  // what: 0 = request seen, 1 = valid output, 2 = redirect fired on request, 3 = grant
  task automatic run_until(input int what, input logic stl, input logic rd_on_req,
                           input logic [31:0] rpc, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(1'b0, stl, 1'b0, rpc, rd_on_req);
      case (what)
        0:       hit = s_req;
        1:       hit = s_valid;
        2:       hit = s_fired;
        default: hit = s_gnt;
      endcase
    end
    if (!hit) begin
      nchk++; nerr++;
      $display("FAIL %s: timeout got none expected event %0d", name, what);
    end
  endtask

  initial begin
    reset = 1; fetch_stall = 0; redirect = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    @(posedge clk);

    // zero-wait memory: one instruction every two cycles
    step(1, 0, 0, 0, 0);
    chk("reset_req", s_req, 0);
    step(0, 0, 0, 0, 0);
    chk("first_addr", s_addr, 32'h0040_0000);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("first_pc", s_pc, 32'h0040_0004);
    chk("first_ins", s_ins, mem_word(32'h0040_0000));
    step(0, 0, 0, 0, 0);
    chk("gap_valid", s_valid, 0);

    // stall five cycles with a full buffer
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      chk("stall_pc", s_pc, 32'h0040_0008);
      chk("stall_req", s_req, 0);
    end
    step(0, 0, 0, 0, 0);
    chk("release_req", s_req, 1);
    chk("release_addr", s_addr, 32'h0040_0008);
    step(0, 0, 0, 0, 0);
    chk("consumed", s_valid, 0);
    step(0, 0, 0, 0, 0);
    chk("third_pc", s_pc, 32'h0040_000C);

    // redirect coincident with grant for 0x40
    step(0, 0, 1, 32'h40, 0);
    run_until(2, 0, 1, 32'h100, "gnt40");
    chk("rd_gnt_addr", s_addr, 32'h40);
    chk("rd_gnt", s_gnt, 1);
    run_until(0, 0, 0, 0, "req100");
    chk("target_addr", s_addr, 32'h100);
    run_until(1, 0, 0, 0, "valid104");
    chk("target_pc", s_pc, 32'h104);

    // redirect with buffer valid and stalled
    run_until(1, 1, 0, 0, "valid_stalled");
    step(0, 1, 1, 32'h200, 0);
    step(0, 1, 0, 0, 0);
    chk("flush_valid", s_valid, 0);
    chk("flush_pc", s_pc, 0);
    chk("flush_ins", s_ins, 0);
    run_until(1, 0, 0, 0, "valid204");
    chk("resume_pc", s_pc, 32'h204);

    // wrap at top of address space; low bits of target ignored
    step(0, 0, 1, 32'hFFFF_FFFE, 0);
    run_until(0, 0, 0, 0, "req_top");
    chk("top_addr", s_addr, 32'hFFFF_FFFC);
    run_until(1, 0, 0, 0, "valid_wrap");
    chk("wrap_pc", s_pc, 32'h0);
    chk("wrap_next_addr", s_addr, 32'h0);

    // slow memory, reset while a response is outstanding
    g_dly = 3; r_dly = 2;
    run_until(3, 0, 0, 0, "slow_gnt");
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_pc", s_pc, 0);
    chk("rst_addr", s_addr, RPC);
    run_until(1, 0, 0, 0, "valid_after_rst");
    chk("rst_first_pc", s_pc, 32'h0040_0004);
    chk("rst_first_ins", s_ins, mem_word(RPC));

    // randomized traffic
    rnd_mem = 1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0,
           ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that produces the instruction/PC pair consumed by the IF/ID pipeline register. It owns the program counter and runs a single-outstanding request/grant/response handshake to instruction memory. It holds one fetched instruction until the decode side accepts it, and honours stall and redirect (flush) requests from the hazard and branch logic. Its outputs feed the IF/ID register's instruction and PC inputs directly, and bubbles are presented as all-zero (NOP).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fetch_stall  in  1  decode side cannot accept this cycle; this is the inverse of the IF/ID write enable.
- redirect  in  1  branch/jump taken or flush; restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch byte address, word-aligned.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
- ins_out  out  32  instruction to IF/ID; 0 when not valid.
- pc_out  out  32  PC+4 of ins_out; 0 when not valid.
- ins_valid  out  1  ins_out/pc_out hold a real instruction.

## Operation
- State registers:
  - pc: next address to fetch.
  - pc_inflight: address of the outstanding request.
  - Output buffer: ins_out, pc_out, ins_valid.
  - FSM state.
- FSM states:
  - FETCH: imem_req = buf_free, imem_addr = pc.
  - WAIT: request outstanding, imem_req = 0.
  - DRAIN: outstanding response must be discarded, imem_req = 0.
- buf_free = !ins_valid | !fetch_stall. A request is only issued when the buffer is empty or being consumed, so the buffer is always empty when a response arrives.
- Consume: ins_valid & !fetch_stall clears ins_valid and zeroes ins_out/pc_out, unless a response loads the buffer in the same cycle.
- FETCH & imem_req & imem_gnt: pc_inflight <= pc, pc <= pc + 4, go to WAIT.
- WAIT & imem_rvalid:
  - ins_out <= imem_rdata, pc_out <= pc_inflight + 4, ins_valid <= 1.
  - Go to FETCH.
- DRAIN & imem_rvalid: discard the data, go to FETCH.
- imem_rvalid in FETCH is ignored. This covers stale responses after reset.
- Redirect has highest priority:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - ins_valid <= 0, ins_out <= 0, pc_out <= 0.
  - FETCH & gnt same cycle → DRAIN, because the old address was accepted.
  - FETCH, no gnt → stay FETCH; the address changes next cycle, which is legal while ungranted.
  - WAIT, no rvalid → DRAIN.
  - WAIT or DRAIN with rvalid same cycle → data discarded, FETCH.
  - DRAIN, no rvalid → stay DRAIN with the updated pc.
- Arithmetic: all PC adds are 32-bit modulo. 32'hFFFF_FFFC + 4 = 0, with no error.
- The memory must hold imem_rdata meaningful only while imem_rvalid is high. It must never return rvalid without a prior grant, except stale responses after reset, which are ignored.

## Timing
- Reset, applied one cycle:
  - pc = RESET_PC, state = FETCH.
  - ins_out = 0, pc_out = 0, ins_valid = 0.
  - imem_req = 0 while reset is high.
- imem_req, imem_addr: combinational from state, pc, ins_valid and fetch_stall. No combinational path from imem_gnt or imem_rvalid to outputs.
- Latency: gnt in cycle N, rvalid in cycle N+1 → ins_valid high in cycle N+2.
- Throughput with zero-wait memory: one instruction per 2 cycles.
- Stall holds ins_out/pc_out/ins_valid stable for any number of cycles. No request is issued while the buffer is full and stalled.
- A redirect takes effect on the next edge. The first post-redirect request appears in the cycle after the redirect, or after the drain completes.
- Reset mid-operation: all state returns to reset values. An outstanding response is dropped.

## Structure
- Shared package cpu_pkg:
  - fetch_state_t enum {FETCH, WAIT, DRAIN}.
  - INSTR_BYTES = 4.
  - NOP_INSTR = 32'h0.
- Single module; no sub-module needed. The output buffer is three registers inline.

## Test plan
- Reset with RESET_PC=32'h0040_0000, zero-wait memory → first imem_addr=0x00400000. Then ins_valid rises with pc_out=0x00400004, then 0x00400008, one instruction every 2 cycles.
- Response arrives, then fetch_stall held 5 cycles → ins_out/pc_out unchanged, imem_req=0 throughout. Release → consumed, next request the same cycle.
- redirect with redirect_pc=0x100 in the same cycle as gnt for 0x40 → DRAIN. The response for 0x40 is discarded. The next imem_addr=0x100, and the next valid pc_out=0x104.
- redirect while the buffer is valid and stalled → ins_valid=0, ins_out=0, pc_out=0 next cycle. Fetch resumes at the target.
- pc=0xFFFFFFFC fetch → pc_out=0x00000000, next imem_addr=0x00000000.
- Memory with 3-cycle gnt delay and 2-cycle rvalid delay, with reset asserted while in WAIT → outputs zeroed, late rvalid ignored, fetch restarts at RESET_PC.
